// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour real-time clock counting on a 1 Hz edge, with
// NUM_ALARMS independent alarm channels. Each channel has its own enable, a
// ring/snooze state machine and an automatic ring timeout. Time is kept in
// binary and decoded to BCD digits combinationally for the display.
//
// Optional feature macro: MULTI_ALARM_SNOOZE_EN
//   defined   - SNOOZED state, snooze counter and the snooze input are live.
//   undefined - snooze is ignored, alarm_snoozed is tied low, and a ringing
//               channel leaves only via stop_al, timeout, al_en low or a
//               reload of its alarm time.
module multi_alarm_clock #(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SEL_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  reset,
  input  logic                  clk_1s,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  ld_time,
  input  logic                  ld_alarm,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] al_en,
  input  logic                  stop_al,
  input  logic                  snooze,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic [NUM_ALARMS-1:0] alarm_ring,
  output logic [NUM_ALARMS-1:0] alarm_snoozed,
  output logic                  alarm_any,
  output logic                  ld_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1,
    ST_SNZ  = 2'd2
  } ch_state_t;

  // Last ring-counter value before a ringing channel clears itself.
  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

`ifdef MULTI_ALARM_SNOOZE_EN
  // Snooze countdown start; expiry is detected at zero, hence the -1.
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60 - 1);
`else
  logic unused_cfg;
  assign unused_cfg = snooze | (SNOOZE_MIN == 0);
`endif

  // Binary to BCD split for values 0..59.
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;

  logic [4:0] in_hh;
  logic [5:0] in_mm;
  logic       digits_ok;
  logic       time_ok;
  logic       sel_ok;
  logic       alarm_ok;
  logic       alarm_ld;

  // Load digits decoded to binary; the range checks make overflow on
  // out-of-range digits irrelevant because such loads are rejected.
  assign in_hh     = {3'b000, H_in1} * 5'd10 + {1'b0, H_in0};
  assign in_mm     = {2'b00, M_in1} * 6'd10 + {2'b00, M_in0};
  assign digits_ok = (H_in1 <= 2'd2) && (H_in0 <= 4'd9) &&
                     (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
  assign time_ok   = digits_ok && (in_hh <= 5'd23);
  assign sel_ok    = (int'(alarm_sel) < NUM_ALARMS);
  assign alarm_ok  = time_ok && sel_ok;
  assign alarm_ld  = ld_alarm && alarm_ok;

  // Time of day: reset and ld_time preload hh:mm:00; a rejected ld_time
  // freezes the time for that edge, otherwise count one second per edge.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      hh <= time_ok ? in_hh : 5'd0;
      mm <= time_ok ? in_mm : 6'd0;
      ss <= 6'd0;
    end else if (ld_time) begin
      if (time_ok) begin
        hh <= in_hh;
        mm <= in_mm;
        ss <= 6'd0;
      end
    end else if (ss == 6'd59) begin
      ss <= 6'd0;
      if (mm == 6'd59) begin
        mm <= 6'd0;
        hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end else begin
        mm <= mm + 6'd1;
      end
    end else begin
      ss <= ss + 6'd1;
    end
  end

  // Load error flag: one cycle after any rejected load request.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= (ld_time && !time_ok) || (ld_alarm && !alarm_ok);
    end
  end

  assign H_out1 = 2'(bcd_tens({1'b0, hh}));
  assign H_out0 = bcd_ones({1'b0, hh});
  assign M_out1 = bcd_tens(mm);
  assign M_out0 = bcd_ones(mm);
  assign S_out1 = bcd_tens(ss);
  assign S_out0 = bcd_ones(ss);

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic [4:0] al_hh;
    logic [5:0] al_mm;
    ch_state_t  state;
    ch_state_t  nxt_state;
    logic [7:0] ring_cnt;
    logic [7:0] nxt_ring_cnt;
`ifdef MULTI_ALARM_SNOOZE_EN
    logic [11:0] snz_cnt;
    logic [11:0] nxt_snz_cnt;
`endif
    logic       sel_hit;
    logic       match;
    logic       ring;
    logic       snzd;

    // A match compares the pre-edge time against hh:mm:00 and is
    // suppressed whenever the clock itself is being loaded.
    assign sel_hit = alarm_ld && (alarm_sel == SEL_W'(g));
    assign match   = al_en[g] && !ld_time && (ss == 6'd0) &&
                     (hh == al_hh) && (mm == al_mm);

    // Alarm time storage for this channel.
    always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
        al_hh <= 5'd0;
        al_mm <= 6'd0;
      end else if (sel_hit) begin
        al_hh <= in_hh;
        al_mm <= in_mm;
      end
    end

    // Channel state and counters.
    always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
        state    <= ST_IDLE;
        ring_cnt <= 8'd0;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt  <= 12'd0;
`endif
      end else begin
        state    <= nxt_state;
        ring_cnt <= nxt_ring_cnt;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_cnt  <= nxt_snz_cnt;
`endif
      end
    end

    // Next-state logic: disable and alarm reload override everything,
    // then stop > snooze > timeout/expiry > match.
    always_comb begin
      nxt_state    = state;
      nxt_ring_cnt = ring_cnt;
`ifdef MULTI_ALARM_SNOOZE_EN
      nxt_snz_cnt  = snz_cnt;
`endif
      if (!al_en[g] || sel_hit) begin
        nxt_state = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (match) begin
              nxt_state    = ST_RING;
              nxt_ring_cnt = 8'd0;
            end
          end
          ST_RING: begin
            if (stop_al) begin
              nxt_state = ST_IDLE;
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            else if (snooze) begin
              nxt_state   = ST_SNZ;
              nxt_snz_cnt = SNZ_LOAD;
            end
`endif
            else if (ring_cnt == RING_LAST) begin
              nxt_state = ST_IDLE;
            end else begin
              nxt_ring_cnt = ring_cnt + 8'd1;
            end
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          ST_SNZ: begin
            if (stop_al) begin
              nxt_state = ST_IDLE;
            end else if (snz_cnt == 12'd0) begin
              nxt_state    = ST_RING;
              nxt_ring_cnt = 8'd0;
            end else begin
              nxt_snz_cnt = snz_cnt - 12'd1;
            end
          end
`endif
          default: nxt_state = ST_IDLE;
        endcase
      end
    end

    // Per-channel status outputs decoded from the state.
    always_comb begin
      ring = (state == ST_RING);
`ifdef MULTI_ALARM_SNOOZE_EN
      snzd = (state == ST_SNZ);
`else
      snzd = 1'b0;
`endif
    end

    assign alarm_ring[g] = ring;
`ifdef MULTI_ALARM_SNOOZE_EN
    assign alarm_snoozed[g] = snzd;
`else
    logic unused_snzd;
    assign unused_snzd = snzd;
`endif
  end

`ifndef MULTI_ALARM_SNOOZE_EN
  assign alarm_snoozed = '0;
`endif

  assign alarm_any = |alarm_ring;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Testbench for multi_alarm_clock: directed scenarios plus randomized
// traffic, checked every cycle against a seconds-of-day behavioural model.
module tb_multi_alarm_clock;

  localparam int NA   = 4;
  localparam int SMIN = 1;
  localparam int RTO  = 60;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic          reset = 1'b0;
  logic          clk_1s = 1'b0;
  logic [1:0]    H_in1 = '0;
  logic [3:0]    H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic          ld_time = 1'b0, ld_alarm = 1'b0;
  logic [1:0]    alarm_sel = '0;
  logic [NA-1:0] al_en = '0;
  logic          stop_al = 1'b0, snooze = 1'b0;
  logic [1:0]    H_out1;
  logic [3:0]    H_out0, M_out1, M_out0, S_out1, S_out0;
  logic [NA-1:0] alarm_ring, alarm_snoozed;
  logic          alarm_any, ld_err;

  multi_alarm_clock #(
    .NUM_ALARMS(NA), .SNOOZE_MIN(SMIN), .RING_TIMEOUT_S(RTO)
  ) dut (
    .reset(reset), .clk_1s(clk_1s),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .alarm_sel(alarm_sel),
    .al_en(al_en), .stop_al(stop_al), .snooze(snooze),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0),
    .alarm_ring(alarm_ring), .alarm_snoozed(alarm_snoozed),
    .alarm_any(alarm_any), .ld_err(ld_err)
  );

  always #5 clk_1s = ~clk_1s;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: time as seconds of the day, alarms as minutes of the
  // day, each channel as idle/ringing/snoozed with seconds-remaining timers.
  int m_t;
  int m_al[NA];
  int m_st[NA];        // 0 idle, 1 ringing, 2 snoozed
  int m_ring_left[NA];
  int m_snz_left[NA];
  bit m_err;
  bit mdl_on = 1'b0;

  function automatic bit in_valid();
    int ih;
    ih = H_in1 * 10 + H_in0;
    return (H_in1 <= 2) && (H_in0 <= 9) && (M_in1 <= 5) && (M_in0 <= 9) && (ih <= 23);
  endfunction

  function automatic int in_minutes();
    return (H_in1 * 10 + H_in0) * 60 + M_in1 * 10 + M_in0;
  endfunction

  task automatic model_reset();
    m_t = in_valid() ? in_minutes() * 60 : 0;
    for (int i = 0; i < NA; i++) begin
      m_al[i] = 0;
      m_st[i] = 0;
      m_ring_left[i] = 0;
      m_snz_left[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit tok, aok;
    int pre;
    tok = in_valid();
    aok = tok && (alarm_sel < NA);
    pre = m_t;
    m_err = (ld_time && !tok) || (ld_alarm && !aok);
    for (int i = 0; i < NA; i++) begin
      if (!al_en[i] || (ld_alarm && aok && alarm_sel == i)) begin
        m_st[i] = 0;
      end else if (m_st[i] == 0) begin
        if (!ld_time && pre == m_al[i] * 60) begin
          m_st[i] = 1;
          m_ring_left[i] = RTO;
        end
      end else if (m_st[i] == 1) begin
        if (stop_al) m_st[i] = 0;
        else if (SNZ_EN && snooze) begin
          m_st[i] = 2;
          m_snz_left[i] = SMIN * 60;
        end else begin
          m_ring_left[i]--;
          if (m_ring_left[i] == 0) m_st[i] = 0;
        end
      end else begin
        if (stop_al) m_st[i] = 0;
        else begin
          m_snz_left[i]--;
          if (m_snz_left[i] == 0) begin
            m_st[i] = 1;
            m_ring_left[i] = RTO;
          end
        end
      end
    end
    if (ld_alarm && aok) m_al[alarm_sel] = in_minutes();
    if (ld_time) begin
      if (tok) m_t = in_minutes() * 60;
    end else begin
      m_t = (m_t + 1) % 86400;
    end
  endtask

  function automatic logic [NA-1:0] m_vec(input int code);
    logic [NA-1:0] v;
    for (int i = 0; i < NA; i++) v[i] = (m_st[i] == code);
    return v;
  endfunction

  always @(posedge clk_1s) begin
    if (mdl_on && !reset) model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_1s) begin : cmp_p
    int h, mi, s;
    logic [21:0] exp_t;
    if (mdl_on) begin
      h  = m_t / 3600;
      mi = (m_t / 60) % 60;
      s  = m_t % 60;
      exp_t = {2'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
      chk("time", {10'd0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, {10'd0, exp_t});
      chk("hour_below_24", 32'((H_out1 * 10 + H_out0) < 24), 32'd1);
      chk("alarm_ring", 32'(alarm_ring), 32'(m_vec(1)));
      chk("alarm_snoozed", 32'(alarm_snoozed), 32'(m_vec(2)));
      chk("alarm_any", 32'(alarm_any), 32'(|m_vec(1)));
      chk("ld_err", 32'(ld_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk_1s);
    @(negedge clk_1s);
    #1;
  endtask

  task automatic set_hm(input int h, input int m);
    H_in1 = 2'(h / 10);
    H_in0 = 4'(h % 10);
    M_in1 = 4'(m / 10);
    M_in0 = 4'(m % 10);
  endtask

  function automatic logic [31:0] tnow();
    return {10'd0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  function automatic logic [31:0] tlit(input int h, input int m, input int s);
    return {10'd0, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int n;
    bit seen;
    int r, tgt;

    // Reset with inputs 23:59 loads the clock asynchronously.
    set_hm(23, 59);
    #1 reset = 1'b1;
    #1;
    model_reset();
    mdl_on = 1'b1;
    chk("reset_time", tnow(), tlit(23, 59, 0));
    chk("reset_ring", 32'(alarm_ring), 32'd0);
    chk("reset_snoozed", 32'(alarm_snoozed), 32'd0);
    chk("reset_any", 32'(alarm_any), 32'd0);
    chk("reset_ld_err", 32'(ld_err), 32'd0);
    @(negedge clk_1s);
    @(negedge clk_1s);
    #1 reset = 1'b0;
    step();
    chk("first_edge", tnow(), tlit(23, 59, 1));
    for (int i = 0; i < 59; i++) step();
    chk("midnight_wrap", tnow(), tlit(0, 0, 0));

    // Invalid loads: 24:00 for the time, minute tens 6 for an alarm.
    set_hm(24, 0);
    ld_time = 1'b1;
    step();
    ld_time = 1'b0;
    chk("bad_time_held", tnow(), tlit(0, 0, 0));
    chk("bad_time_err", 32'(ld_err), 32'd1);
    step();
    chk("bad_time_err_clear", 32'(ld_err), 32'd0);
    chk("bad_time_resume", tnow(), tlit(0, 0, 1));
    H_in1 = 2'd0; H_in0 = 4'd7; M_in1 = 4'd6; M_in0 = 4'd0;
    alarm_sel = 2'd0;
    ld_alarm = 1'b1;
    step();
    ld_alarm = 1'b0;
    chk("bad_alarm_err", 32'(ld_err), 32'd1);
    chk("bad_alarm_time_runs", tnow(), tlit(0, 0, 2));
    step();
    chk("bad_alarm_err_clear", 32'(ld_err), 32'd0);

    // Match and timeout on channel 2 at 07:30.
    set_hm(7, 30);
    alarm_sel = 2'd2;
    ld_alarm = 1'b1;
    step();
    ld_alarm = 1'b0;
    set_hm(7, 29);
    ld_time = 1'b1;
    al_en = 4'b0100;
    step();
    ld_time = 1'b0;
    for (int i = 0; i < 58; i++) step();
    chk("setup_time", tnow(), tlit(7, 29, 58));
    step();
    step();
    chk("no_ring_at_match", 32'(alarm_ring), 32'd0);
    step();
    chk("ring_ch2", 32'(alarm_ring), 32'b0100);
    chk("ring_time", tnow(), tlit(7, 30, 1));
    n = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (alarm_ring[2]) n++;
      else break;
    end
    chk("ring_cycles", 32'(n), 32'd60);

    // Simultaneous time and alarm load of 08:00 on channel 0.
    set_hm(8, 0);
    alarm_sel = 2'd0;
    al_en = 4'b0001;
    ld_time = 1'b1;
    ld_alarm = 1'b1;
    step();
    ld_time = 1'b0;
    ld_alarm = 1'b0;
    chk("dual_load_time", tnow(), tlit(8, 0, 0));
    chk("dual_load_no_ring", 32'(alarm_ring), 32'd0);
    step();
    chk("ch0_ring", 32'(alarm_ring), 32'b0001);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
    chk("snoozed_ch0", 32'(alarm_snoozed), 32'b0001);
    chk("snoozed_not_ring", 32'(alarm_ring), 32'd0);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (alarm_ring[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rering_seen", 32'(seen), 32'd1);
    chk("rering_delay", 32'(n), 32'd60);
`else
    chk("snooze_ignored_ring", 32'(alarm_ring), 32'b0001);
    chk("snooze_ignored_flag", 32'(alarm_snoozed), 32'd0);
`endif
    stop_al = 1'b1;
    step();
    stop_al = 1'b0;
    chk("stop_ring", 32'(alarm_ring), 32'd0);
    chk("stop_snoozed", 32'(alarm_snoozed), 32'd0);

    // Shared match at 12:00 on channels 0 and 1.
    set_hm(12, 0);
    alarm_sel = 2'd0;
    ld_alarm = 1'b1;
    step();
    alarm_sel = 2'd1;
    step();
    ld_alarm = 1'b0;
    set_hm(11, 59);
    ld_time = 1'b1;
    al_en = 4'b0011;
    step();
    ld_time = 1'b0;
    for (int i = 0; i < 61; i++) step();
    chk("shared_ring", 32'(alarm_ring), 32'b0011);
    chk("shared_time", tnow(), tlit(12, 0, 1));
    al_en = 4'b0001;
    step();
    chk("ch1_disabled", 32'(alarm_ring), 32'b0001);

    // Asynchronous reset while channel 0 rings.
    set_hm(9, 15);
    reset = 1'b1;
    #1;
    chk("async_reset_ring", 32'(alarm_ring), 32'd0);
    chk("async_reset_any", 32'(alarm_any), 32'd0);
    chk("async_reset_snoozed", 32'(alarm_snoozed), 32'd0);
    chk("async_reset_time", tnow(), tlit(9, 15, 0));
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk("post_reset_no_ring", 32'(alarm_ring), 32'd0);
    chk("post_reset_time", tnow(), tlit(9, 15, 3));

    // Randomized traffic.
    al_en = 4'hF;
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      ld_time = 1'b0;
      ld_alarm = 1'b0;
      stop_al = ($urandom_range(0, 39) == 0);
      snooze = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) al_en = 4'($urandom);
      else if ($urandom_range(0, 49) == 0) al_en = 4'hF;
      H_in1 = 2'($urandom); H_in0 = 4'($urandom);
      M_in1 = 4'($urandom); M_in0 = 4'($urandom);
      alarm_sel = 2'($urandom_range(0, 3));
      if (r < 2) begin
        ld_time = 1'b1;
        if ($urandom_range(0, 3) != 0) set_hm($urandom_range(0, 23), $urandom_range(0, 59));
      end else if (r < 11) begin
        ld_alarm = 1'b1;
        ld_time = (r == 10);
        if ($urandom_range(0, 4) != 0) begin
          tgt = (m_t / 60 + $urandom_range(0, 2)) % 1440;
          set_hm(tgt / 60, tgt % 60);
        end
      end
      step();
    end
    ld_time = 1'b0;
    ld_alarm = 1'b0;
    stop_al = 1'b0;
    snooze = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Real-time 24-hour clock with `NUM_ALARMS` independently programmable alarm channels. Each channel has its own enable, a ring/snooze state machine and an automatic ring timeout. The block counts on the 1 Hz `clk_1s` produced by the clock-divider stage and drives BCD time digits to the display logic. It is the multi-channel successor to the single-alarm clock and corrects the hour wrap so that hour 24 never appears.

## Interface
- `NUM_ALARMS`, 4: number of alarm channels, 1..16.
- `SNOOZE_MIN`, 5: snooze length in minutes, 1..59.
- `RING_TIMEOUT_S`, 60: seconds a channel rings before it auto-clears, 1..255.
- `SEL_W`, `$clog2(NUM_ALARMS)` (minimum 1): width of `alarm_sel`.

Ports, clock and reset first:
- `reset` input 1: reset, asynchronous, active-high.
- `clk_1s` input 1: clock, one rising edge per real-time second.
- `H_in1` input 2, `H_in0` input 4, `M_in1` input 4, `M_in0` input 4: BCD hh:mm load value.
- `ld_time` input 1: load the clock from the `*_in` digits; seconds are set to 00.
- `ld_alarm` input 1: load alarm channel `alarm_sel` from the `*_in` digits.
- `alarm_sel` input `SEL_W`: alarm channel index for `ld_alarm`.
- `al_en` input `NUM_ALARMS`: per-channel enable.
- `stop_al` input 1: clear every ringing and snoozed channel.
- `snooze` input 1: move every ringing channel to SNOOZED.
- `H_out1` output 2, `H_out0` output 4, `M_out1` output 4, `M_out0` output 4, `S_out1` output 4, `S_out0` output 4: BCD current time.
- `alarm_ring` output `NUM_ALARMS`: per-channel ringing.
- `alarm_snoozed` output `NUM_ALARMS`: per-channel snoozed.
- `alarm_any` output 1: OR of `alarm_ring`.
- `ld_err` output 1: registered; high for one `clk_1s` cycle after a rejected load.

## Operation
- **Time storage.** Time is held as binary `hh` (5b), `mm` (6b), `ss` (6b). Output BCD digits are decoded combinationally from those registers.
- **Counting.** With no load, each edge increments `ss`.
  - 59→0 carries into `mm`; 59→0 carries into `hh`.
  - 23:59:59 → 00:00:00.
- **Load validation.** A load is valid only if `H_in1`≤2, `H_in0`≤9, `M_in1`≤5, `M_in0`≤9 and hh≤23.
  - Invalid `ld_time` or `ld_alarm`: registers are left unchanged and `ld_err`=1 on the next cycle.
  - `ld_alarm` with `alarm_sel`≥`NUM_ALARMS` is also invalid.
- **Alarm storage.** Each channel stores hh (5b) and mm (6b). The seconds compare value is fixed at 00.
- **Channel FSM states.** Each channel has states IDLE, RINGING and SNOOZED, with an 8-bit ring counter and a 12-bit snooze counter.
- **IDLE → RINGING.** Taken when all of the following hold: `al_en[i]`=1, pre-edge time == alarm hh:mm:00, and `ld_time`=0 on that edge. The ring counter is cleared.
- **RINGING.**
  - `stop_al` → IDLE.
  - Else `snooze` → SNOOZED, with the snooze counter loaded with `SNOOZE_MIN*60-1`.
  - Else if ring counter == `RING_TIMEOUT_S-1` → IDLE.
  - Else the ring counter increments.
- **SNOOZED.**
  - `stop_al` → IDLE.
  - Else if snooze counter == 0 → RINGING, ring counter cleared.
  - Else decrement.
  - A match while SNOOZED is ignored.
- **Overrides.**
  - `al_en[i]`=0 forces channel i to IDLE on the next edge, taking precedence over all transitions.
  - A valid `ld_alarm` to channel i also forces it to IDLE.
- **Outputs.** `alarm_ring[i]` = (state==RINGING); `alarm_snoozed[i]` = (state==SNOOZED).

## Timing
- **Reset values.**
  - Time = `*_in` hh:mm:00 if valid, else 00:00:00.
  - All alarms 00:00, all channels IDLE.
  - `alarm_ring`=0, `alarm_snoozed`=0, `alarm_any`=0, `ld_err`=0.
- **Load latency.** A load sampled on edge n is visible on the outputs after edge n. No increment happens on edge n.
- **Alarm latency.** When the time shows hh:mm:00, ringing appears one edge later, together with hh:mm:01.
- **Priority within one edge.** reset > `al_en` low > valid `ld_alarm` (channel i) > `stop_al` > `snooze` > timeout/expiry > match.
- **Simultaneous loads.** `ld_time` and `ld_alarm` on the same edge are both applied.
  - A match on that edge is suppressed.
  - `ld_err` = OR of the two rejections.
- **Reset mid-ring.** Reset clears the channel state immediately and asynchronously. No ring resumes after reset release.
- **Shared match.** Multiple channels matching the same time all ring on the same edge.

## Configuration
- Macro `MULTI_ALARM_SNOOZE_EN`.
- **Defined:** SNOOZED state, snooze counter and the `snooze` input are active as described above.
- **Undefined:**
  - The `snooze` port still exists but is ignored.
  - The SNOOZED state and snooze counter are not synthesised.
  - `alarm_snoozed` is tied to 0.
  - RINGING exits only via `stop_al`, timeout, `al_en` low or `ld_alarm`.

## Test plan
- **Reset load.** Reset with in=23:59 and release; wait 1 edge → 23:59:01. Wait 59 edges → 00:00:00, never showing hour 24.
- **Invalid loads.** `ld_time` with 24:00 → time unchanged, `ld_err`=1 for 1 cycle. `ld_alarm` with M_in1=6 → same rejection behaviour.
- **Match and timeout.**
  - Setup: alarm ch2=07:30, `al_en`=4'b0100, time 07:29:58.
  - Expected: `alarm_ring`=4'b0100 first appears with 07:30:01.
  - With `RING_TIMEOUT_S`=60 it clears after 60 ringing cycles.
- **Snooze and stop.** Ringing ch0, pulse `snooze` → `alarm_snoozed[0]`=1. With `SNOOZE_MIN`=1, it re-rings exactly 60 edges later. Then `stop_al` → IDLE.
- **Simultaneous match.** ch0 and ch1 both set to 12:00, both enabled → both ring on the same edge. On that ringing edge, `al_en[1]`=0 → ch1 drops next edge, ch0 keeps ringing.
- **Configuration and reset.** Without `MULTI_ALARM_SNOOZE_EN`, `snooze` during a ring → still ringing, `alarm_snoozed`=0. Asserting reset mid-ring → all outputs 0 immediately.
